// File: rtl/axi_bram_arbiter_if.sv
// -----------------------------------------------------------------------------
// axi_bram_arbiter_if
// AXI-MM bundle (AW, W, B, AR, R) that can be N_PORTS wide. Requester-side
// buses put port i at bit i and at slice [i*W +: W]. N_PORTS=2 is the shared
// requester side of the arbiter; N_PORTS=1 is the link to the BRAM slave.
//
// Modports:
//   master : drives AW/W/AR payload and valid, B/R ready; receives the rest
//   slave  : the mirror image of master
// -----------------------------------------------------------------------------
interface axi_bram_arbiter_if #(
    parameter int N_PORTS     = 1,
    parameter int AXI_IDWIDTH = 4,
    parameter int AXI_AWIDTH  = 64,
    parameter int AXI_DWIDTH  = 256
);
    // Write address
    logic [N_PORTS-1:0]                  awvalid;
    logic [N_PORTS-1:0]                  awready;
    logic [N_PORTS*AXI_AWIDTH-1:0]       awaddr;
    logic [N_PORTS*8-1:0]                awlen;
    logic [N_PORTS*AXI_IDWIDTH-1:0]      awid;
    // Write data
    logic [N_PORTS-1:0]                  wvalid;
    logic [N_PORTS-1:0]                  wready;
    logic [N_PORTS-1:0]                  wlast;
    logic [N_PORTS*AXI_DWIDTH-1:0]       wdata;
    logic [N_PORTS*AXI_DWIDTH/8-1:0]     wstrb;
    // Write response
    logic [N_PORTS-1:0]                  bvalid;
    logic [N_PORTS-1:0]                  bready;
    logic [N_PORTS*AXI_IDWIDTH-1:0]      bid;
    logic [N_PORTS*2-1:0]                bresp;
    // Read address
    logic [N_PORTS-1:0]                  arvalid;
    logic [N_PORTS-1:0]                  arready;
    logic [N_PORTS*AXI_AWIDTH-1:0]       araddr;
    logic [N_PORTS*8-1:0]                arlen;
    logic [N_PORTS*AXI_IDWIDTH-1:0]      arid;
    // Read data
    logic [N_PORTS-1:0]                  rvalid;
    logic [N_PORTS-1:0]                  rready;
    logic [N_PORTS-1:0]                  rlast;
    logic [N_PORTS*AXI_DWIDTH-1:0]       rdata;
    logic [N_PORTS*AXI_IDWIDTH-1:0]      rid;
    logic [N_PORTS*2-1:0]                rresp;

    modport master (
        output awvalid, awaddr, awlen, awid,
        input  awready,
        output wvalid, wlast, wdata, wstrb,
        input  wready,
        input  bvalid, bid, bresp,
        output bready,
        output arvalid, araddr, arlen, arid,
        input  arready,
        input  rvalid, rlast, rdata, rid, rresp,
        output rready
    );

    modport slave (
        input  awvalid, awaddr, awlen, awid,
        output awready,
        input  wvalid, wlast, wdata, wstrb,
        output wready,
        output bvalid, bid, bresp,
        input  bready,
        input  arvalid, araddr, arlen, arid,
        output arready,
        output rvalid, rlast, rdata, rid, rresp,
        input  rready
    );
endinterface

// File: rtl/axi_bram_arbiter.sv
// -----------------------------------------------------------------------------
// axi_bram_arbiter
// Shares one AXI slave (BRAM endpoint) between two AXI masters. Write and
// read paths are arbitrated independently, round-robin on ties. The write
// grant is held until the B handshake, the read grant until the last R beat.
// Payload (IDs, addresses, lengths, data, responses) passes through unchanged.
//
// Ports:
//   clk    : single clock
//   rstn   : asynchronous active-low reset
//   s_axi  : requester side, two ports (0 = PCIe BAR master, 1 = DMA engine)
//   m_axi  : single port toward the BRAM slave
// -----------------------------------------------------------------------------
module axi_bram_arbiter #(
    parameter int AXI_IDWIDTH = 4,
    parameter int AXI_AWIDTH  = 64,
    parameter int AXI_DWIDTH  = 256
) (
    input  logic                 clk,
    input  logic                 rstn,
    axi_bram_arbiter_if.slave    s_axi,
    axi_bram_arbiter_if.master   m_axi
);
    localparam int IW = AXI_IDWIDTH;
    localparam int AW = AXI_AWIDTH;
    localparam int DW = AXI_DWIDTH;
    localparam int SW = AXI_DWIDTH / 8;

    typedef enum logic [1:0] {W_IDLE, W_GRANT, W_RESP} wstate_e;
    typedef enum logic       {R_IDLE, R_GRANT}         rstate_e;

    wstate_e wstate_q, wstate_d;
    logic    wgnt_q, wgnt_d;
    logic    wlast_gnt_q, wlast_gnt_d;
    logic    aw_done_q, aw_done_d;
    logic    w_done_q, w_done_d;

    rstate_e rstate_q, rstate_d;
    logic    rgnt_q, rgnt_d;
    logic    rlast_gnt_q, rlast_gnt_d;
    logic    ar_done_q, ar_done_d;

    // With two requesters, round-robin reduces to: on a tie the one that was
    // not served last wins; a lone request wins outright.
    function automatic logic rr_pick(input logic [1:0] req, input logic last);
        return (req == 2'b11) ? ~last : req[1];
    endfunction

    // Reset leaves last-grant at 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wstate_q    <= W_IDLE;
            wgnt_q      <= 1'b0;
            wlast_gnt_q <= 1'b1;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            rstate_q    <= R_IDLE;
            rgnt_q      <= 1'b0;
            rlast_gnt_q <= 1'b1;
            ar_done_q   <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every
            // register samples the pre-edge value of every other.
            wstate_q    <= wstate_d;
            wgnt_q      <= wgnt_d;
            wlast_gnt_q <= wlast_gnt_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            rstate_q    <= rstate_d;
            rgnt_q      <= rgnt_d;
            rlast_gnt_q <= rlast_gnt_d;
            ar_done_q   <= ar_done_d;
        end
    end

    // Payload muxes select by the registered grant; valids are gated below,
    // so the payload seen while idle is don't-care.
    assign m_axi.awaddr = wgnt_q ? s_axi.awaddr[AW +: AW] : s_axi.awaddr[0 +: AW];
    assign m_axi.awlen  = wgnt_q ? s_axi.awlen[8 +: 8]    : s_axi.awlen[0 +: 8];
    assign m_axi.awid   = wgnt_q ? s_axi.awid[IW +: IW]   : s_axi.awid[0 +: IW];
    assign m_axi.wdata  = wgnt_q ? s_axi.wdata[DW +: DW]  : s_axi.wdata[0 +: DW];
    assign m_axi.wstrb  = wgnt_q ? s_axi.wstrb[SW +: SW]  : s_axi.wstrb[0 +: SW];
    assign m_axi.wlast  = s_axi.wlast[wgnt_q];
    assign m_axi.araddr = rgnt_q ? s_axi.araddr[AW +: AW] : s_axi.araddr[0 +: AW];
    assign m_axi.arlen  = rgnt_q ? s_axi.arlen[8 +: 8]    : s_axi.arlen[0 +: 8];
    assign m_axi.arid   = rgnt_q ? s_axi.arid[IW +: IW]   : s_axi.arid[0 +: IW];

    // Response payload is broadcast to both requesters; only the granted
    // one ever sees the matching valid.
    assign s_axi.bid   = {2{m_axi.bid}};
    assign s_axi.bresp = {2{m_axi.bresp}};
    assign s_axi.rdata = {2{m_axi.rdata}};
    assign s_axi.rid   = {2{m_axi.rid}};
    assign s_axi.rresp = {2{m_axi.rresp}};
    assign s_axi.rlast = {2{m_axi.rlast}};

    // Write path
    always_comb begin
        // NOTE: every output and next-state gets a default first, so no
        // path through the case statement can leave a latch behind.
        wstate_d      = wstate_q;
        wgnt_d        = wgnt_q;
        wlast_gnt_d   = wlast_gnt_q;
        aw_done_d     = aw_done_q;
        w_done_d      = w_done_q;
        m_axi.awvalid = 1'b0;
        m_axi.wvalid  = 1'b0;
        m_axi.bready  = 1'b0;
        s_axi.awready = 2'b00;
        s_axi.wready  = 2'b00;
        s_axi.bvalid  = 2'b00;
        unique case (wstate_q)
            W_IDLE: begin
                if (|s_axi.awvalid) begin
                    wgnt_d   = rr_pick(s_axi.awvalid, wlast_gnt_q);
                    wstate_d = W_GRANT;
                end
            end
            W_GRANT: begin
                // Each channel is gated off once its part of the burst is done,
                // so AW and the W burst may finish in either order.
                m_axi.awvalid         = s_axi.awvalid[wgnt_q] & ~aw_done_q;
                s_axi.awready[wgnt_q] = m_axi.awready & ~aw_done_q;
                m_axi.wvalid          = s_axi.wvalid[wgnt_q] & ~w_done_q;
                s_axi.wready[wgnt_q]  = m_axi.wready & ~w_done_q;
                if (m_axi.awvalid && m_axi.awready) aw_done_d = 1'b1;
                if (m_axi.wvalid && m_axi.wready && m_axi.wlast) w_done_d = 1'b1;
                if (aw_done_d && w_done_d) wstate_d = W_RESP;
            end
            W_RESP: begin
                s_axi.bvalid[wgnt_q] = m_axi.bvalid;
                m_axi.bready         = s_axi.bready[wgnt_q];
                if (m_axi.bvalid && m_axi.bready) begin
                    wlast_gnt_d = wgnt_q;
                    aw_done_d   = 1'b0;
                    w_done_d    = 1'b0;
                    wstate_d    = W_IDLE;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    // Read path
    always_comb begin
        rstate_d      = rstate_q;
        rgnt_d        = rgnt_q;
        rlast_gnt_d   = rlast_gnt_q;
        ar_done_d     = ar_done_q;
        m_axi.arvalid = 1'b0;
        m_axi.rready  = 1'b0;
        s_axi.arready = 2'b00;
        s_axi.rvalid  = 2'b00;
        unique case (rstate_q)
            R_IDLE: begin
                if (|s_axi.arvalid) begin
                    rgnt_d   = rr_pick(s_axi.arvalid, rlast_gnt_q);
                    rstate_d = R_GRANT;
                end
            end
            R_GRANT: begin
                m_axi.arvalid         = s_axi.arvalid[rgnt_q] & ~ar_done_q;
                s_axi.arready[rgnt_q] = m_axi.arready & ~ar_done_q;
                s_axi.rvalid[rgnt_q]  = m_axi.rvalid;
                m_axi.rready          = s_axi.rready[rgnt_q];
                if (m_axi.arvalid && m_axi.arready) ar_done_d = 1'b1;
                if (m_axi.rvalid && m_axi.rready && m_axi.rlast) begin
                    rlast_gnt_d = rgnt_q;
                    ar_done_d   = 1'b0;
                    rstate_d    = R_IDLE;
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end
endmodule

// File: tb/tb_axi_bram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axi_bram_arbiter
// Self-checking bench for axi_bram_arbiter: a cycle table for the write
// arbitration/handshake sequence, plus directed write/read sequences driven
// by a small behavioural slave.
// -----------------------------------------------------------------------------
module tb_axi_bram_arbiter;
    localparam int IW = 4;
    localparam int AW = 64;
    localparam int DW = 256;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    axi_bram_arbiter_if #(.N_PORTS(2), .AXI_IDWIDTH(IW), .AXI_AWIDTH(AW), .AXI_DWIDTH(DW)) s_if ();
    axi_bram_arbiter_if #(.N_PORTS(1), .AXI_IDWIDTH(IW), .AXI_AWIDTH(AW), .AXI_DWIDTH(DW)) m_if ();

    axi_bram_arbiter #(.AXI_IDWIDTH(IW), .AXI_AWIDTH(AW), .AXI_DWIDTH(DW)) dut (
        .clk   (clk),
        .rstn  (rstn),
        .s_axi (s_if),
        .m_axi (m_if)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Every ready/valid the arbiter drives, concatenated.
    function automatic logic [14:0] hs_bits();
        return {s_if.awready, s_if.wready, s_if.bvalid, s_if.arready, s_if.rvalid,
                m_if.awvalid, m_if.wvalid, m_if.bready, m_if.arvalid, m_if.rready};
    endfunction

    task automatic clear_inputs();
        s_if.awvalid = '0; s_if.awaddr = '0; s_if.awlen = '0; s_if.awid = '0;
        s_if.wvalid  = '0; s_if.wlast  = '0; s_if.wdata = '0; s_if.wstrb = '0;
        s_if.bready  = '0;
        s_if.arvalid = '0; s_if.araddr = '0; s_if.arlen = '0; s_if.arid = '0;
        s_if.rready  = '0;
        m_if.awready = '0; m_if.wready = '0;
        m_if.bvalid  = '0; m_if.bid = '0; m_if.bresp = '0;
        m_if.arready = '0;
        m_if.rvalid  = '0; m_if.rlast = '0; m_if.rdata = '0; m_if.rid = '0; m_if.rresp = '0;
    endtask

    // One row per clock cycle of the write path. x_out packs the expected
    // {m_awvalid, s_awready[1:0], m_wvalid, s_wready[1:0], s_bvalid[1:0], m_bready}.
    typedef struct packed {
        logic [1:0] awv;
        logic [1:0] wv;
        logic       awr;
        logic       wr;
        logic       bv;
        logic [1:0] bready;
        logic [8:0] x_out;
        logic [3:0] x_id;
    } wvec_t;

    wvec_t wtab [13];

    // Write one burst of `beats` beats from requester `req`; W may lead AW by
    // `w_lead` cycles. The slave is always ready and answers B once both the
    // AW and the last W beat have been accepted.
    task automatic run_write(input int req, input logic [63:0] addr, input logic [3:0] id,
                             input int beats, input int w_lead, input string tag);
        int beat    = 0;
        int other   = 1 - req;
        bit aw_done = 1'b0;
        bit w_done  = 1'b0;
        bit b_done  = 1'b0;
        for (int cyc = 0; cyc < 64 && !b_done; cyc++) begin
            s_if.awvalid[req]           = !aw_done && cyc >= w_lead;
            s_if.awaddr[req*AW +: AW]   = addr;
            s_if.awlen[req*8 +: 8]      = 8'(beats - 1);
            s_if.awid[req*IW +: IW]     = id;
            s_if.wvalid[req]            = beat < beats;
            s_if.wlast[req]             = beat == beats - 1;
            s_if.wdata[req*DW +: DW]    = DW'(32'h1000 * 32'(req + 1) + 32'(beat));
            s_if.wstrb[req*(DW/8) +: DW/8] = '1;
            s_if.bready[req]            = 1'b1;
            m_if.awready = 1'b1;
            m_if.wready  = 1'b1;
            m_if.bvalid  = aw_done && w_done;
            m_if.bid     = id;
            m_if.bresp   = 2'b01;
            #2;
            check({tag, "_other_idle"},
                  64'({s_if.awready[other], s_if.wready[other], s_if.bvalid[other]}), 64'd0);
            check({tag, "_m_awvalid"}, 64'(m_if.awvalid), 64'(cyc == w_lead + 1));
            check({tag, "_s_wready"}, 64'(s_if.wready[req]), 64'(cyc > w_lead && beat < beats));
            check({tag, "_m_bready"}, 64'(m_if.bready), 64'(aw_done && w_done));
            if (m_if.awvalid && m_if.awready) begin
                check({tag, "_awaddr"}, m_if.awaddr, addr);
                check({tag, "_awlen"}, 64'(m_if.awlen), 64'(beats - 1));
                check({tag, "_awid"}, 64'(m_if.awid), 64'(id));
                aw_done = 1'b1;
            end
            if (s_if.wvalid[req] && s_if.wready[req]) begin
                check({tag, "_wdata"}, 64'(m_if.wdata[31:0]), 64'(32'h1000 * 32'(req + 1) + 32'(beat)));
                check({tag, "_wstrb"}, 64'(m_if.wstrb), 64'hFFFF_FFFF);
                check({tag, "_wlast"}, 64'(m_if.wlast), 64'(beat == beats - 1));
                if (beat == beats - 1) w_done = 1'b1;
                beat++;
            end
            if (m_if.bvalid && m_if.bready) begin
                check({tag, "_s_bvalid"}, 64'(s_if.bvalid[req]), 64'd1);
                check({tag, "_bid"}, 64'(s_if.bid[req*IW +: IW]), 64'(id));
                check({tag, "_bresp"}, 64'(s_if.bresp[req*2 +: 2]), 64'(2'b01));
                b_done = 1'b1;
            end
            step();
        end
        check({tag, "_b_done"}, 64'(b_done), 64'd1);
        check({tag, "_beats"}, 64'(beat), 64'(beats));
        // A stale slave B must not reach anyone once the burst is closed.
        s_if.awvalid[req] = 1'b0;
        s_if.wvalid[req]  = 1'b0;
        m_if.bvalid       = 1'b1;
        #2;
        check({tag, "_post_bready"}, 64'(m_if.bready), 64'd0);
        check({tag, "_post_bvalid"}, 64'(s_if.bvalid), 64'd0);
        m_if.bvalid      = 1'b0;
        s_if.bready[req] = 1'b0;
        step();
    endtask

    // Read a burst of len+1 beats for requester `req`; the slave streams beats
    // after the AR handshake. With `toggle` set the requester is ready only on
    // odd cycles.
    task automatic run_read(input int req, input logic [63:0] addr, input logic [3:0] id,
                            input int len, input bit toggle, input string tag);
        int beat    = 0;
        int other   = 1 - req;
        bit ar_done = 1'b0;
        bit done    = 1'b0;
        bit rr;
        bit rv;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            rr = toggle ? (cyc % 2 == 1) : 1'b1;
            rv = ar_done && beat <= len;
            s_if.arvalid[req]         = !ar_done;
            s_if.araddr[req*AW +: AW] = addr;
            s_if.arlen[req*8 +: 8]    = 8'(len);
            s_if.arid[req*IW +: IW]   = id;
            s_if.rready[req]          = rr;
            m_if.arready = 1'b1;
            m_if.rvalid  = rv;
            m_if.rdata   = DW'(32'hA000 + 32'(beat));
            m_if.rlast   = beat == len;
            m_if.rid     = id;
            m_if.rresp   = 2'b01;
            #2;
            check({tag, "_other_idle"}, 64'({s_if.arready[other], s_if.rvalid[other]}), 64'd0);
            check({tag, "_m_arvalid"}, 64'(m_if.arvalid), 64'(cyc == 1));
            check({tag, "_m_rready"}, 64'(m_if.rready), 64'(cyc >= 1 && rr));
            check({tag, "_s_rvalid"}, 64'(s_if.rvalid[req]), 64'(rv));
            if (m_if.arvalid && m_if.arready) begin
                check({tag, "_araddr"}, m_if.araddr, addr);
                check({tag, "_arlen"}, 64'(m_if.arlen), 64'(len));
                check({tag, "_arid"}, 64'(m_if.arid), 64'(id));
                ar_done = 1'b1;
            end
            if (rv && m_if.rready) begin
                check({tag, "_rdata"}, 64'(s_if.rdata[req*DW +: 32]), 64'(32'hA000 + 32'(beat)));
                check({tag, "_rlast"}, 64'(s_if.rlast[req]), 64'(beat == len));
                check({tag, "_rid"}, 64'(s_if.rid[req*IW +: IW]), 64'(id));
                if (beat == len) done = 1'b1;
                beat++;
            end
            step();
        end
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_beats"}, 64'(beat), 64'(len + 1));
        // Grant must be released right after the rlast beat.
        s_if.arvalid[req] = 1'b0;
        s_if.rready[req]  = 1'b1;
        m_if.rvalid       = 1'b1;
        #2;
        check({tag, "_post_rready"}, 64'(m_if.rready), 64'd0);
        check({tag, "_post_rvalid"}, 64'(s_if.rvalid), 64'd0);
        m_if.rvalid      = 1'b0;
        s_if.rready[req] = 1'b0;
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Write-path cycle table: tie after reset goes to 0, then 1 (AW stalled,
        // W first), then a tie goes to 0 again with B held off by bready.
        //          awv    wv     awr   wr    bv    bready x_out          x_id
        wtab[0]  = '{2'b11, 2'b11, 1'b1, 1'b1, 1'b0, 2'b11, 9'b0_00_0_00_00_0, 4'd0};
        wtab[1]  = '{2'b11, 2'b11, 1'b1, 1'b1, 1'b0, 2'b11, 9'b1_01_1_01_00_0, 4'd5};
        wtab[2]  = '{2'b10, 2'b10, 1'b1, 1'b1, 1'b1, 2'b11, 9'b0_00_0_00_01_1, 4'd0};
        wtab[3]  = '{2'b10, 2'b10, 1'b1, 1'b1, 1'b0, 2'b11, 9'b0_00_0_00_00_0, 4'd0};
        wtab[4]  = '{2'b10, 2'b10, 1'b0, 1'b1, 1'b0, 2'b11, 9'b1_00_1_10_00_0, 4'd9};
        wtab[5]  = '{2'b10, 2'b00, 1'b1, 1'b1, 1'b0, 2'b11, 9'b1_10_0_00_00_0, 4'd9};
        wtab[6]  = '{2'b11, 2'b11, 1'b1, 1'b1, 1'b0, 2'b10, 9'b0_00_0_00_00_1, 4'd0};
        wtab[7]  = '{2'b11, 2'b11, 1'b1, 1'b1, 1'b1, 2'b10, 9'b0_00_0_00_10_1, 4'd0};
        wtab[8]  = '{2'b11, 2'b11, 1'b1, 1'b1, 1'b0, 2'b10, 9'b0_00_0_00_00_0, 4'd0};
        wtab[9]  = '{2'b11, 2'b11, 1'b1, 1'b1, 1'b0, 2'b10, 9'b1_01_1_01_00_0, 4'd5};
        wtab[10] = '{2'b00, 2'b00, 1'b1, 1'b1, 1'b1, 2'b00, 9'b0_00_0_00_01_0, 4'd0};
        wtab[11] = '{2'b00, 2'b00, 1'b1, 1'b1, 1'b1, 2'b01, 9'b0_00_0_00_01_1, 4'd0};
        wtab[12] = '{2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 2'b00, 9'b0_00_0_00_00_0, 4'd0};

        // Reset with every input asserted: nothing may leak through.
        clear_inputs();
        s_if.awvalid = 2'b11; s_if.wvalid = 2'b11; s_if.bready = 2'b11;
        s_if.arvalid = 2'b11; s_if.rready = 2'b11;
        m_if.awready = 1'b1; m_if.wready = 1'b1; m_if.bvalid = 1'b1;
        m_if.arready = 1'b1; m_if.rvalid = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        check("reset_outputs", 64'(hs_bits()), 64'd0);
        clear_inputs();
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // Table-driven write arbitration
        s_if.awid = {4'd9, 4'd5};
        for (int i = 0; i < 13; i++) begin
            s_if.awvalid = wtab[i].awv;
            s_if.wvalid  = wtab[i].wv;
            s_if.wlast   = wtab[i].wv;
            m_if.awready = wtab[i].awr;
            m_if.wready  = wtab[i].wr;
            m_if.bvalid  = wtab[i].bv;
            s_if.bready  = wtab[i].bready;
            #2;
            check($sformatf("wtab[%0d]", i),
                  64'({m_if.awvalid, s_if.awready, m_if.wvalid, s_if.wready, s_if.bvalid, m_if.bready}),
                  64'(wtab[i].x_out));
            if (wtab[i].x_out[8]) check($sformatf("wtab[%0d]_awid", i), 64'(m_if.awid), 64'(wtab[i].x_id));
            step();
        end
        clear_inputs();
        step();

        // Single 4-beat write from requester 0
        run_write(0, 64'h40, 4'd5, 4, 0, "wr0_single");

        // Concurrent: requester 0 writes len 7, requester 1 reads len 3
        fork
            run_write(0, 64'h1000, 4'd6, 8, 0, "conc_wr0");
            run_read(1, 64'h2000, 4'd11, 3, 1'b0, "conc_rd1");
        join

        // W presented three cycles ahead of AW
        run_write(1, 64'h200, 4'd3, 1, 3, "w_first");

        // len-15 read with the requester ready only every other cycle
        run_read(0, 64'h300, 4'd7, 15, 1'b1, "rd_bp");

        // Reset in the middle of a 4-beat write, after two beats
        s_if.awvalid[0] = 1'b1;
        s_if.awaddr[0 +: AW] = 64'h500;
        s_if.awlen[0 +: 8] = 8'd3;
        s_if.awid[0 +: IW] = 4'd2;
        s_if.wvalid[0] = 1'b1;
        s_if.wstrb[0 +: DW/8] = '1;
        s_if.bready[0] = 1'b1;
        m_if.awready = 1'b1;
        m_if.wready = 1'b1;
        step();
        s_if.awvalid[0] = 1'b0;
        repeat (2) step();
        #1;
        check("rst_pre_wready", 64'(s_if.wready), 64'(2'b01));
        #1;
        rstn = 1'b0;
        #1;
        check("rst_mid_outputs", 64'(hs_bits()), 64'd0);
        clear_inputs();
        @(negedge clk);
        rstn = 1'b1;
        run_write(1, 64'h600, 4'd9, 2, 0, "post_rst_wr1");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
